// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: state encoding,
// registered output bundle and counter sizing.
package pll_seq_pkg;

    localparam int unsigned RETRY_W = 8;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    typedef struct packed {
        logic pll_rst;
        logic core_reset;
        logic ready;
        logic fault;
    } ctrl_t;

    // Counter must hold the largest per-state cycle count.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $unsigned($clog2(m)) + 32'd1;
    endfunction

    // Moore output decode for a given state.
    function automatic ctrl_t decode(input state_e s);
        ctrl_t o;
        o.pll_rst    = (s == RESET_PLL);
        o.core_reset = (s != RUN);
        o.ready      = (s == RUN);
        o.fault      = (s == FAULT);
        return o;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL / core control bundle between the reset sequencer and the chip top.
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_lock;
    logic               relock_req;
    logic               pll_rst;
    logic               core_reset;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  pll_lock, relock_req,
        output pll_rst, core_reset, ready, fault, retry_count
    );

    modport slave (
        output pll_lock, relock_req,
        input  pll_rst, core_reset, ready, fault, retry_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases the core;
// retries on lock timeout and parks in FAULT once retries are exhausted.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                         sys_clock,
    input  logic                         reset_n,
    pll_reset_sequencer_if.master        bus
);

    localparam int unsigned CNT_W =
        cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    ctrl_t              out_q, out_d;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk   (sys_clock),
        .rst_n (reset_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= decode(RESET_PLL);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    // Outputs are decoded from the next state so the registers track the state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    retry_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s || bus.relock_req) state_d = RESET_PLL;
            end
            FAULT: begin
                if (bus.relock_req) begin
                    retry_d = '0;
                    state_d = RESET_PLL;
                end
            end
            default: state_d = RESET_PLL;
        endcase

        // Shared dwell counter: restarts on any transition, saturates otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        out_d = decode(state_d);
    end

    assign bus.pll_rst     = out_q.pll_rst;
    assign bus.core_reset  = out_q.core_reset;
    assign bus.ready       = out_q.ready;
    assign bus.fault       = out_q.fault;
    assign bus.retry_count = retry_q;

endmodule
